tt_capture: RTL and testbench
=============================

Name: tt_capture

Overview:
Sequential exhaustive tester for a 3-input combinational function block such as the team's B/C/D→Y gate-level circuits. It drives all eight input combinations {b,c,d} = 0..7 into the block under test and samples its output y_in after a programmable settle time. It assembles the results into an 8-bit truth table and compares that table against an expected constant. It sits beside the combinational block on the lab board/bench and reports pass or fail plus a per-minterm mismatch mask.

Parameters:
EXPECTED, 8'hA2, expected truth table; bit i = Y for {b,c,d}=i (8'hA2 = D&(B|~C))
SETTLE, 1, extra cycles each vector is held before sampling (0..15); each vector occupies SETTLE+1 cycles

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous active-high reset
start  input  1  begin a capture run; sampled only in IDLE
y_in  input  1  output of the block under test
b  output  1  drive to input B of the block under test
c  output  1  drive to input C of the block under test
d  output  1  drive to input D of the block under test
busy  output  1  high while a run is in progress
done  output  1  one-cycle pulse when the run completes
table  output  8  captured truth table; bit i = sampled y_in for vector i
fail_mask  output  8  table ^ EXPECTED, valid from done onward
pass  output  1  1 when table == EXPECTED, valid from done onward

Behaviour:
- One clock domain (clk). Reset is synchronous and active-high on rst. All outputs are registered.
- Reset values: state=IDLE, {b,c,d}=3'b000, busy=0, done=0, table=8'h00, fail_mask=8'h00, pass=0. Internal idx=0 and cnt=0.
- FSM states: IDLE, DRIVE, DONE.
- IDLE, start=1 at an edge:
  - Enter DRIVE; busy=1.
  - idx=0, cnt=0, {b,c,d}=0.
  - table, fail_mask and pass cleared to 0.
- IDLE, start=0: hold all outputs, including results from the previous run.
- DRIVE, at each edge:
  - cnt<SETTLE: cnt++.
  - cnt==SETTLE: table[idx] <= y_in.
    - idx<7: idx++, cnt=0, {b,c,d} <= idx+1.
    - idx==7: enter DONE; fail_mask <= new table ^ EXPECTED; pass <= (new table == EXPECTED).
- DONE lasts exactly one cycle:
  - done=1, busy=0.
  - Next edge returns to IDLE; done falls.
  - {b,c,d} stays at 3'b111 until the next start.
- Latency: the start edge is T0. Vector k (k=0..7) is sampled at edge T0+(k+1)(SETTLE+1). done is high during the cycle after edge T0+8(SETTLE+1).
- table fills progressively during a run; only the value from done onward is final.
- start in DRIVE or DONE is ignored; start is not queued.
- start held high continuously: a new run begins on the first IDLE cycle, one cycle after done.
- rst mid-run: the run is aborted, all reset values are applied, and no done pulse is produced. rst has priority over start.
- SETTLE=0 is legal: one cycle per vector, 8-cycle run.

Test Plan:
- Ideal DUT (y_in = d&(b|~c)), SETTLE=1, start pulsed at T0: done pulses in the cycle after T0+16, table=8'hA2, fail_mask=8'h00, pass=1, busy high for exactly 16 cycles.
- y_in stuck at 0: table=8'h00, fail_mask=8'hA2, pass=0. y_in stuck at 1: table=8'hFF, fail_mask=8'h5D, pass=0.
- Faulty DUT y_in = d (missing the C term): table=8'hAA, fail_mask=8'h08, pass=0.
- start re-pulsed at T0+5 mid-run: ignored, done still in the cycle after T0+16, single done pulse. Then a second start clears table to 0 at the next edge, and the rerun yields 8'hA2 again.
- rst asserted at T0+7: next cycle busy=0, table=0, {b,c,d}=000, no done pulse. A subsequent start completes normally.
- SETTLE=0 with ideal DUT: {b,c,d} steps 0..7 on consecutive cycles, done in the cycle after T0+8, pass=1. SETTLE=3: done in the cycle after T0+32.

Source files
------------

// File: rtl/tt_capture.sv
// Exhaustive tester for a 3-input combinational block: it steps {b,c,d} through 0..7,
// samples y_in after each vector settles, and compares the captured truth table to EXPECTED.
module tt_capture #(
    parameter logic [7:0]  EXPECTED = 8'hA2,
    parameter int unsigned SETTLE   = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       y_in,
    output logic       b,
    output logic       c,
    output logic       d,
    output logic       busy,
    output logic       done,
    output logic [7:0] truth_table,
    output logic [7:0] fail_mask,
    output logic       pass
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [3:0] SETTLE_C = 4'(SETTLE);

    state_t     state_q, state_d;
    logic [2:0] idx_q, idx_d;
    logic [3:0] cnt_q, cnt_d;
    logic [2:0] bcd_q, bcd_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic [7:0] table_q, table_d;
    logic [7:0] fail_q, fail_d;
    logic       pass_q, pass_d;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        bcd_d   = bcd_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        table_d = table_q;
        fail_d  = fail_q;
        pass_d  = pass_q;
        case (state_q)
            IDLE: begin
                // Previous results stay visible until the next run is requested.
                if (start) begin
                    state_d = DRIVE;
                    busy_d  = 1'b1;
                    idx_d   = 3'd0;
                    cnt_d   = 4'd0;
                    bcd_d   = 3'd0;
                    table_d = 8'h00;
                    fail_d  = 8'h00;
                    pass_d  = 1'b0;
                end
            end
            DRIVE: begin
                if (cnt_q != SETTLE_C) begin
                    cnt_d = cnt_q + 4'd1;
                end else begin
                    table_d[idx_q] = y_in;
                    if (idx_q != 3'd7) begin
                        idx_d = idx_q + 3'd1;
                        cnt_d = 4'd0;
                        bcd_d = idx_q + 3'd1;
                    end else begin
                        // Verdict uses the table including the bit captured this edge.
                        state_d = DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        fail_d  = table_d ^ EXPECTED;
                        pass_d  = (table_d == EXPECTED);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= 3'd0;
            cnt_q   <= 4'd0;
            bcd_q   <= 3'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            table_q <= 8'h00;
            fail_q  <= 8'h00;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            bcd_q   <= bcd_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            table_q <= table_d;
            fail_q  <= fail_d;
            pass_q  <= pass_d;
        end
    end

    assign b           = bcd_q[2];
    assign c           = bcd_q[1];
    assign d           = bcd_q[0];
    assign busy        = busy_q;
    assign done        = done_q;
    assign truth_table = table_q;
    assign fail_mask   = fail_q;
    assign pass        = pass_q;

endmodule

// File: tb/tb_tt_capture.sv
// Bench for tt_capture: three instances (SETTLE=1,0,3) checked every cycle against a
// timing-based model, plus literal latency/result expectations for each scenario.
module tb_tt_capture;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    int   mode = 0;

    always #5 clk = ~clk;

    logic [2:0]      b_w, c_w, d_w, y_w, busy_w, done_w, pass_w;
    logic [2:0][7:0] tab_w, fail_w;

    function automatic int sval(int g);
        return (g == 0) ? 1 : ((g == 1) ? 0 : 3);
    endfunction

    // Block-under-test behaviour: 0 ideal D&(B|~C), 1 stuck-0, 2 stuck-1, 3 Y=D
    function automatic logic fref(int md, int k);
        logic [2:0] v;
        v = k[2:0];
        case (md)
            0: return v[0] & (v[2] | ~v[1]);
            1: return 1'b0;
            2: return 1'b1;
            default: return v[0];
        endcase
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_dut
        assign y_w[g] = fref(mode, int'({b_w[g], c_w[g], d_w[g]}));
        tt_capture #(.EXPECTED(8'hA2), .SETTLE(sval(g))) u_dut (
            .clk        (clk),
            .rst        (rst),
            .start      (start),
            .y_in       (y_w[g]),
            .b          (b_w[g]),
            .c          (c_w[g]),
            .d          (d_w[g]),
            .busy       (busy_w[g]),
            .done       (done_w[g]),
            .truth_table(tab_w[g]),
            .fail_mask  (fail_w[g]),
            .pass       (pass_w[g])
        );
    end

    // Model: t = edges since the start edge; vector k sampled at t=(k+1)(S+1); done at t=8(S+1)
    bit         m_run [3];
    int         m_t   [3];
    logic [7:0] m_tab [3];
    logic [7:0] m_fail[3];
    logic       m_pass[3];
    logic [2:0] m_bcd [3];

    int cyc = 0;
    int n_chk = 0, n_err = 0;
    int c0 = 0;
    int done_cnt[3], done_cyc[3], busy_cnt[3];
    bit chk_en = 1'b0;

    task automatic chk(string name, int act, int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) begin
        cyc++;
        for (int g = 0; g < 3; g++) begin
            int s, len, k;
            s   = sval(g) + 1;
            len = 8 * s;
            if (rst) begin
                m_run[g] = 1'b0; m_t[g] = 0; m_tab[g] = 8'h00;
                m_fail[g] = 8'h00; m_pass[g] = 1'b0; m_bcd[g] = 3'd0;
            end else if (m_run[g]) begin
                if (m_t[g] == len) begin
                    m_run[g] = 1'b0;
                end else begin
                    m_t[g]++;
                    if (m_t[g] % s == 0) begin
                        k = m_t[g] / s - 1;
                        m_tab[g][k] = fref(mode, k);
                    end
                    if (m_t[g] == len) begin
                        m_fail[g] = m_tab[g] ^ 8'hA2;
                        m_pass[g] = (m_tab[g] == 8'hA2);
                    end else begin
                        m_bcd[g] = 3'(m_t[g] / s);
                    end
                end
            end else if (start) begin
                m_run[g] = 1'b1; m_t[g] = 0; m_tab[g] = 8'h00;
                m_fail[g] = 8'h00; m_pass[g] = 1'b0; m_bcd[g] = 3'd0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int g = 0; g < 3; g++) begin
                int len;
                len = 8 * (sval(g) + 1);
                chk($sformatf("busy[%0d]", g), busy_w[g], int'(m_run[g] && m_t[g] < len));
                chk($sformatf("done[%0d]", g), done_w[g], int'(m_run[g] && m_t[g] == len));
                chk($sformatf("bcd[%0d]", g), {b_w[g], c_w[g], d_w[g]}, m_bcd[g]);
                chk($sformatf("table[%0d]", g), tab_w[g], m_tab[g]);
                chk($sformatf("fail_mask[%0d]", g), fail_w[g], m_fail[g]);
                chk($sformatf("pass[%0d]", g), pass_w[g], m_pass[g]);
                if (busy_w[g]) busy_cnt[g]++;
                if (done_w[g]) begin
                    done_cnt[g]++;
                    done_cyc[g] = cyc;
                end
            end
        end
    end

    task automatic clear_counts();
        for (int g = 0; g < 3; g++) begin
            done_cnt[g] = 0; busy_cnt[g] = 0; done_cyc[g] = -1;
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        c0 = cyc + 1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(int lim);
        for (int n = 0; n < lim; n++) begin
            @(negedge clk);
            if (busy_w == 3'b000 && done_w == 3'b000) return;
        end
        chk("wait_idle_timeout", 1, 0);
    endtask

    task automatic run_case(int md, logic [7:0] et, logic [7:0] ef, logic ep);
        mode = md;
        clear_counts();
        pulse_start();
        wait_idle(60);
        chk("latency_s1", done_cyc[0] - c0, 16);
        chk("latency_s0", done_cyc[1] - c0, 8);
        chk("latency_s3", done_cyc[2] - c0, 32);
        chk("busy_cycles_s1", busy_cnt[0], 16);
        chk("busy_cycles_s0", busy_cnt[1], 8);
        chk("done_pulses_s1", done_cnt[0], 1);
        chk("lit_table_s1", tab_w[0], et);
        chk("lit_table_s3", tab_w[2], et);
        chk("lit_fail_s0", fail_w[1], ef);
        chk("lit_pass_s1", pass_w[0], ep);
        chk("lit_bcd_end", {b_w[0], c_w[0], d_w[0]}, 7);
    endtask

    initial begin
        clear_counts();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        chk("rst_busy", busy_w[0], 0);
        chk("rst_done", done_w[0], 0);
        chk("rst_table", tab_w[0], 8'h00);
        chk("rst_bcd", {b_w[0], c_w[0], d_w[0]}, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        run_case(0, 8'hA2, 8'h00, 1'b1);
        run_case(1, 8'h00, 8'hA2, 1'b0);
        run_case(2, 8'hFF, 8'h5D, 1'b0);
        run_case(3, 8'hAA, 8'h08, 1'b0);

        // Start re-pulsed mid-run is ignored; a later start clears the table immediately
        mode = 0;
        clear_counts();
        pulse_start();
        repeat (4) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle(60);
        chk("repulse_latency", done_cyc[0] - c0, 16);
        chk("repulse_single_done", done_cnt[0], 1);
        pulse_start();
        chk("restart_clears_table", tab_w[0], 8'h00);
        wait_idle(60);
        chk("rerun_table", tab_w[0], 8'hA2);

        // Reset at T0+7 aborts without a done pulse
        clear_counts();
        pulse_start();
        repeat (6) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", busy_w[0], 0);
        chk("abort_table", tab_w[0], 8'h00);
        chk("abort_bcd", {b_w[0], c_w[0], d_w[0]}, 0);
        repeat (40) @(negedge clk);
        chk("abort_no_done", done_cnt[0] + done_cnt[1] + done_cnt[2], 0);
        run_case(0, 8'hA2, 8'h00, 1'b1);

        // Start held high: back-to-back runs two cycles apart after each done
        clear_counts();
        @(negedge clk);
        start = 1'b1;
        c0 = cyc + 1;
        repeat (40) @(negedge clk);
        start = 1'b0;
        wait_idle(60);
        chk("held_done_count", done_cnt[0], 3);
        chk("held_last_done", done_cyc[0] - c0, 52);
        chk("held_table", tab_w[0], 8'hA2);

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
